// File: rtl/dmem_req_stage_pkg.sv
// Shared types and constants for the data-side memory request stage.
// Exception codes, access sizes, FSM states and store formatting helpers.
package dmem_req_stage_pkg;

   localparam logic [5:0] ECODE_PIL  = 6'h01;
   localparam logic [5:0] ECODE_PIS  = 6'h02;
   localparam logic [5:0] ECODE_PME  = 6'h04;
   localparam logic [5:0] ECODE_PPI  = 6'h07;
   localparam logic [5:0] ECODE_ADE  = 6'h08;
   localparam logic [5:0] ECODE_ALE  = 6'h09;
   localparam logic [5:0] ECODE_TLBR = 6'h3F;

   localparam logic [1:0] SIZE_B = 2'd0;
   localparam logic [1:0] SIZE_H = 2'd1;
   localparam logic [1:0] SIZE_W = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_XLAT  = 2'd1,
      ST_ISSUE = 2'd2,
      ST_EXC   = 2'd3
   } state_t;

   // Size 3 is reserved and behaves as a word access.
   function automatic logic [3:0] fmt_wstrb(
      input logic       we,
      input logic [1:0] size,
      input logic [1:0] va_lo
   );
      logic [3:0] s;
      s = 4'h0;
      if (we) begin
         case (size)
            SIZE_B:  s = 4'b0001 << va_lo;
            SIZE_H:  s = 4'b0011 << {va_lo[1], 1'b0};
            default: s = 4'hF;
         endcase
      end
      return s;
   endfunction

   function automatic logic [31:0] fmt_wdata(
      input logic [1:0]  size,
      input logic [31:0] wd
   );
      logic [31:0] o;
      case (size)
         SIZE_B:  o = {4{wd[7:0]}};
         SIZE_H:  o = {2{wd[15:0]}};
         default: o = wd;
      endcase
      return o;
   endfunction

endpackage

// File: rtl/dmem_req_stage_exc_check.sv
// Priority encoder for data-access exceptions on translator results.
// Alignment check is present only when DMEM_ALIGN_CHECK_EN is defined.
module dmem_exc_check (
   input  logic       trans_en,
   input  logic       found,
   input  logic       v,
   input  logic       d,
   input  logic [1:0] tlb_plv,
   input  logic [1:0] csr_plv,
   input  logic       we,
   input  logic [1:0] size,
   input  logic       va_msb,
   input  logic [1:0] va_lo,
   output logic       exc,
   output logic [5:0] ecode
);

   import dmem_req_stage_pkg::*;

`ifdef DMEM_ALIGN_CHECK_EN
   localparam bit ALE_EN = 1'b1;
`else
   localparam bit ALE_EN = 1'b0;
`endif

   logic misalign;
   logic ale;
   logic adem;

   always_comb begin
      case (size)
         SIZE_B:  misalign = 1'b0;
         SIZE_H:  misalign = va_lo[0];
         default: misalign = |va_lo;
      endcase
   end

   assign ale  = ALE_EN & misalign;
   assign adem = (csr_plv == 2'd3) & va_msb & trans_en;

   // Page-table checks only matter in mapped mode.
   always_comb begin
      exc   = 1'b1;
      ecode = 6'h00;
      if (ale) begin
         ecode = ECODE_ALE;
      end else if (adem) begin
         ecode = ECODE_ADE;
      end else if (trans_en && !found) begin
         ecode = ECODE_TLBR;
      end else if (trans_en && !v) begin
         ecode = we ? ECODE_PIS : ECODE_PIL;
      end else if (trans_en && (csr_plv > tlb_plv)) begin
         ecode = ECODE_PPI;
      end else if (trans_en && we && !d) begin
         ecode = ECODE_PME;
      end else begin
         exc = 1'b0;
      end
   end

endmodule

// File: rtl/dmem_req_stage.sv
// Data memory request stage: translate, check, then issue to dcache.
// Optional alignment exceptions: define DMEM_ALIGN_CHECK_EN.
module dmem_req_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_vaddr,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic [31:0] req_wdata,
   output logic        data_fetch,
   output logic [31:0] data_vaddr,
   input  logic [31:0] data_paddr_out,
   input  logic        data_tlb_found_out,
   input  logic        data_tlb_v_out,
   input  logic        data_tlb_d_out,
   input  logic [1:0]  data_tlb_plv_out,
   input  logic        data_addr_trans_en_out,
   input  logic        data_uncache_en,
   input  logic [1:0]  csr_plv,
   output logic        dc_valid,
   input  logic        dc_ready,
   output logic [31:0] dc_paddr,
   output logic        dc_we,
   output logic [3:0]  dc_wstrb,
   output logic [31:0] dc_wdata,
   output logic        dc_uncache,
   output logic        exc_valid,
   output logic [5:0]  exc_ecode,
   output logic [31:0] exc_badv
);

   import dmem_req_stage_pkg::*;

   state_t      state;
   state_t      state_n;
   logic [31:0] va_q;
   logic [31:0] wdata_q;
   logic        we_q;
   logic [1:0]  size_q;
   logic        issue_q;
   logic        xlat_exc;
   logic [5:0]  xlat_ecode;
   logic        in_xlat;
   logic        dc_fire;

   dmem_exc_check u_exc (
      .trans_en (data_addr_trans_en_out),
      .found    (data_tlb_found_out),
      .v        (data_tlb_v_out),
      .d        (data_tlb_d_out),
      .tlb_plv  (data_tlb_plv_out),
      .csr_plv  (csr_plv),
      .we       (we_q),
      .size     (size_q),
      .va_msb   (va_q[31]),
      .va_lo    (va_q[1:0]),
      .exc      (xlat_exc),
      .ecode    (xlat_ecode)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_comb begin
      state_n = state;
      if (flush) begin
         state_n = ST_IDLE;
      end else begin
         unique case (state)
            ST_IDLE:  if (data_fetch) state_n = ST_XLAT;
            ST_XLAT:  state_n = xlat_exc ? ST_EXC : ST_ISSUE;
            ST_ISSUE: if (dc_fire) state_n = ST_IDLE;
            ST_EXC:   state_n = ST_IDLE;
            default:  state_n = ST_IDLE;
         endcase
      end
   end

   // Address stays on va_q while busy so uncache lookup remains valid.
   always_comb begin
      req_ready  = (state == ST_IDLE) && !flush;
      data_fetch = req_valid && req_ready;
      data_vaddr = data_fetch ? req_vaddr : va_q;
      dc_valid   = issue_q && !flush;
      exc_valid  = (state == ST_EXC) && !flush;
   end

   assign in_xlat = (state == ST_XLAT) && !flush;
   assign dc_fire = dc_valid && dc_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         va_q       <= 32'h0;
         wdata_q    <= 32'h0;
         we_q       <= 1'b0;
         size_q     <= 2'd0;
         issue_q    <= 1'b0;
         dc_paddr   <= 32'h0;
         dc_we      <= 1'b0;
         dc_wstrb   <= 4'h0;
         dc_wdata   <= 32'h0;
         dc_uncache <= 1'b0;
         exc_ecode  <= 6'h00;
         exc_badv   <= 32'h0;
      end else begin
         if (data_fetch) begin
            va_q    <= req_vaddr;
            wdata_q <= req_wdata;
            we_q    <= req_we;
            size_q  <= req_size;
         end
         if (flush || dc_fire) begin
            issue_q <= 1'b0;
         end else if (in_xlat && !xlat_exc) begin
            issue_q <= 1'b1;
         end
         if (in_xlat && xlat_exc) begin
            exc_ecode <= xlat_ecode;
            exc_badv  <= va_q;
         end
         if (in_xlat && !xlat_exc) begin
            dc_paddr   <= data_paddr_out;
            dc_we      <= we_q;
            dc_wstrb   <= fmt_wstrb(we_q, size_q, va_q[1:0]);
            dc_wdata   <= fmt_wdata(size_q, wdata_q);
            dc_uncache <= data_uncache_en;
         end
      end
   end

endmodule

// File: doc/dmem_req_stage.md
# dmem_req_stage

Data-side memory request stage between the execute stage and the data cache, wrapped around the address-translation block's data port. Accepts one load/store per handshake, drives the translator's `data_fetch`/`data_vaddr`, samples the registered translation result one cycle later, performs MMU/alignment exception checks, then either issues a physical request to the dcache (valid/ready, held until accepted) or reports a one-cycle exception. Single outstanding request; flush cancels anything not yet accepted by the dcache.

## Interface
- No parameters.
- `clk` in 1 — clock.
- `rst` in 1 — synchronous, active-high reset.
- `flush` in 1 — pipeline flush from commit.
- `req_valid` in 1 / `req_ready` out 1 — execute-side handshake.
- `req_vaddr` in 32; `req_we` in 1 (1 = store); `req_size` in 2 (0 byte, 1 half, 2 word; 3 reserved, treated as word); `req_wdata` in 32.
- `data_fetch` out 1; `data_vaddr` out 32 — to translator.
- `data_paddr_out` in 32; `data_tlb_found_out`, `data_tlb_v_out`, `data_tlb_d_out` in 1; `data_tlb_plv_out` in 2; `data_addr_trans_en_out` in 1; `data_uncache_en` in 1 — from translator.
- `csr_plv` in 2 — current privilege level.
- `dc_valid` out 1 / `dc_ready` in 1; `dc_paddr` out 32; `dc_we` out 1; `dc_wstrb` out 4; `dc_wdata` out 32; `dc_uncache` out 1 — to dcache.
- `exc_valid` out 1; `exc_ecode` out 6; `exc_badv` out 32 — exception report.

## Operation
- States: IDLE, XLAT, ISSUE, EXC. `req_ready = (state == IDLE)`.
- IDLE: on `req_valid & req_ready` latch vaddr/we/size/wdata into `va_q` etc.; go XLAT. `data_fetch = req_valid & req_ready`; `data_vaddr = data_fetch ? req_vaddr : va_q` (held stable while busy so combinational `data_uncache_en` stays valid).
- XLAT (exactly 1 cycle): evaluate exceptions on translator outputs; register dcache fields or exception fields; go ISSUE or EXC.
- Exception priority (only `data_addr_trans_en_out`-gated terms apply when it is 1): ALE 0x09 (macro-gated) > ADEM 0x08 (`csr_plv==3 & va[31] & trans_en`) > TLBR 0x3F (`!found`) > PIL 0x01 / PIS 0x02 (`!v`, by we) > PPI 0x07 (`csr_plv > tlb_plv`) > PME 0x04 (`we & !d`). `exc_badv = va_q`.
- ISSUE: `dc_valid = issue_q & !flush`; hold all dc_* stable until `dc_valid & dc_ready`, then IDLE.
- EXC: `exc_valid` high one cycle, then IDLE.
- `dc_wstrb`: store byte `4'b0001 << va[1:0]`; half `4'b0011 << {va[1],1'b0}`; word `4'hF`; loads `4'h0`. `dc_wdata`: byte replicated ×4, half ×2, word as-is. `dc_uncache = data_uncache_en` sampled in XLAT.
- `flush` in any state: next state IDLE; `dc_valid` and `exc_valid` forced 0 in the flush cycle; a request arriving with `flush` is not accepted (`req_ready` qualified by `!flush`).

## Timing
- Reset values: state IDLE, `req_ready` 1 after reset, `data_fetch` 0, `data_vaddr` 0, all dc_* 0, `exc_valid` 0, `exc_ecode` 0, `exc_badv` 0.
- Accept at cycle N → XLAT N+1 → `dc_valid` or `exc_valid` at N+2 earliest. Back-to-back throughput: one request per 3 cycles with `dc_ready` constantly 1.
- `dc_ready` low: ISSUE persists indefinitely; outputs unchanged.
- `dc_ready` and `flush` same cycle: no transfer (dc_valid masked).
- `rst` mid-operation: returns to IDLE next edge, no dcache/exception output.

## Configuration
- `DMEM_ALIGN_CHECK_EN` defined: half with `va[0]`, word with `va[1:0]!=0` → ALE 0x09, highest priority, no dcache access.
- Undefined: no alignment check; misaligned accesses issued with low address bits unchanged and strobe computed as above.

## Structure
- Shared package: ecode constants (PIL, PIS, PME, PPI, ADE, ALE, TLBR), size encodings, state encoding.
- One combinational sub-module `dmem_exc_check` (priority encoder: translator flags, plv, size, va low bits → exc flag + ecode); FSM, registers, strobe/wdata formatting in top.

## Test plan
- DA mode, word store 0x1000_0004 data 0xAABBCCDD, `dc_ready`=1 → `dc_valid` at N+2, paddr 0x1000_0004, wstrb 0xF, wdata 0xAABBCCDD.
- Byte store va 0x...03 data 0x5A → wstrb 0x8, wdata 0x5A5A5A5A; `dc_ready` low 4 cycles → fields stable, `req_ready` 0 throughout.
- Paged, translator `found`=0 → `exc_valid` one cycle, ecode 0x3F, badv = va; no `dc_valid`.
- Store with found=1, v=1, d=0, plv ok → ecode 0x04; load same entry → dcache issue. plv3 vs tlb_plv 0 → 0x07.
- With `DMEM_ALIGN_CHECK_EN`: word load va 0x...02 and found=0 → ecode 0x09 (ALE beats TLBR); without macro → ecode 0x3F.
- `flush` asserted in XLAT, and separately in ISSUE with `dc_ready`=1 → no transfer, no exception, IDLE next cycle, next request accepted.
